// File: rtl/i2s_ws_gen_multi.sv
// Frame/word-select generator for the I2S master: DSP short/long, I2S and LJ framing,
// with slot/bit position, strobes, setup delay, polarity and graceful stop.
module i2s_ws_gen_multi #(
    parameter int CNT_W  = 16,
    parameter int SLOT_W = 4,
    parameter int BITS_W = 5
) (
    input  logic              sck_i,
    input  logic              rst_i,
    input  logic              cfg_en_i,
    input  logic [1:0]        cfg_mode_i,
    input  logic [BITS_W-1:0] cfg_num_bits_i,
    input  logic [SLOT_W-1:0] cfg_num_slots_i,
    input  logic [CNT_W-1:0]  cfg_setup_time_i,
    input  logic              cfg_ws_pol_i,
    output logic              ws_o,
    output logic              frame_start_o,
    output logic              slot_start_o,
    output logic [SLOT_W-1:0] slot_idx_o,
    output logic [BITS_W-1:0] bit_idx_o,
    output logic              busy_o,
    output logic              cfg_err_o
);

    typedef enum logic [1:0] {IDLE, SETUP, RUN} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [BITS_W-1:0] bit_q, bit_d;
    logic [1:0]        mode_q;
    logic [BITS_W-1:0] nb_q;
    logic [SLOT_W-1:0] ns_q;
    logic [CNT_W-1:0]  setup_q;
    logic              pol_q;
    logic              ws_q, fs_q, ss_q, busy_q, err_q;
    logic              last_pos;
    logic              bad_cfg;

    // Raw WS at position (s,b); I2S looks one position ahead so WS leads the MSB.
    function automatic logic ws_calc(input logic [1:0]        m,
                                     input logic [BITS_W-1:0] nb,
                                     input logic [SLOT_W-1:0] ns,
                                     input logic [SLOT_W-1:0] s,
                                     input logic [BITS_W-1:0] b);
        logic [SLOT_W-1:0] sn;
        logic              r;
        sn = (b != nb) ? s : ((s == ns) ? '0 : s + SLOT_W'(1));
        case (m)
            2'b00:   r = (s == '0) && (b == '0);
            2'b01:   r = (s == '0);
            2'b10:   r = sn[0];
            default: r = ~s[0];
        endcase
        return r;
    endfunction

    always_comb begin
        last_pos = (slot_q == ns_q) && (bit_q == nb_q);
        bad_cfg  = cfg_mode_i[1] && !cfg_num_slots_i[0];
        bit_d    = (bit_q == nb_q) ? '0 : bit_q + BITS_W'(1);
        slot_d   = slot_q;
        if (bit_q == nb_q) slot_d = (slot_q == ns_q) ? '0 : slot_q + SLOT_W'(1);
    end

    always_ff @(posedge sck_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            slot_q  <= '0;
            bit_q   <= '0;
            mode_q  <= '0;
            nb_q    <= '0;
            ns_q    <= '0;
            setup_q <= '0;
            pol_q   <= 1'b0;
            ws_q    <= 1'b0;
            fs_q    <= 1'b0;
            ss_q    <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ws_q   <= cfg_ws_pol_i;
                    fs_q   <= 1'b0;
                    ss_q   <= 1'b0;
                    busy_q <= 1'b0;
                    slot_q <= '0;
                    bit_q  <= '0;
                    cnt_q  <= '0;
                    if (cfg_en_i) begin
                        if (bad_cfg) begin
                            err_q <= 1'b1;
                        end else begin
                            err_q   <= 1'b0;
                            mode_q  <= cfg_mode_i;
                            nb_q    <= cfg_num_bits_i;
                            ns_q    <= cfg_num_slots_i;
                            setup_q <= cfg_setup_time_i;
                            pol_q   <= cfg_ws_pol_i;
                            busy_q  <= 1'b1;
                            if (cfg_setup_time_i != '0) begin
                                state_q <= SETUP;
                                cnt_q   <= CNT_W'(1);
                            end else begin
                                state_q <= RUN;
                                fs_q    <= 1'b1;
                                ss_q    <= 1'b1;
                                ws_q    <= cfg_ws_pol_i ^ ws_calc(cfg_mode_i,
                                           cfg_num_bits_i, cfg_num_slots_i, '0, '0);
                            end
                        end
                    end
                end
                SETUP: begin
                    if (!cfg_en_i) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        ws_q    <= cfg_ws_pol_i;
                    end else if (cnt_q == setup_q) begin
                        state_q <= RUN;
                        fs_q    <= 1'b1;
                        ss_q    <= 1'b1;
                        ws_q    <= pol_q ^ ws_calc(mode_q, nb_q, ns_q, '0, '0);
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (last_pos && !cfg_en_i) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        fs_q    <= 1'b0;
                        ss_q    <= 1'b0;
                        slot_q  <= '0;
                        bit_q   <= '0;
                        ws_q    <= cfg_ws_pol_i;
                    end else begin
                        slot_q <= slot_d;
                        bit_q  <= bit_d;
                        fs_q   <= (slot_d == '0) && (bit_d == '0);
                        ss_q   <= (bit_d == '0);
                        ws_q   <= pol_q ^ ws_calc(mode_q, nb_q, ns_q, slot_d, bit_d);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ws_o          = ws_q;
    assign frame_start_o = fs_q;
    assign slot_start_o  = ss_q;
    assign slot_idx_o    = slot_q;
    assign bit_idx_o     = bit_q;
    assign busy_o        = busy_q;
    assign cfg_err_o     = err_q;

endmodule
